// File: rtl/noc_pkg.sv
// Shared types and constants for the AXI-to-mesh network interface.
// Flit layout: [33:32] flit type, [31:0] payload.
package noc_pkg;

    localparam int FLIT_W = 34;

    typedef enum logic [1:0] {
        FT_BODY      = 2'b00,
        FT_HEAD      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        PKT_WREQ = 2'd0,
        PKT_RREQ = 2'd1,
        PKT_WRSP = 2'd2,
        PKT_RRSP = 2'd3
    } pkt_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_HEAD,
        S_TX_ADDR,
        S_TX_DATA,
        S_WAIT_RSP,
        S_RX_DATA,
        S_B_OUT,
        S_R_OUT,
        S_W_DRAIN
    } state_e;

    localparam int HB_PKT  = 30;
    localparam int HB_DY   = 28;
    localparam int HB_DX   = 26;
    localparam int HB_SY   = 24;
    localparam int HB_SX   = 22;
    localparam int HB_ID   = 18;
    localparam int HB_RESP = 16;
    localparam int HB_STRB = 12;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef struct packed {
        pkt_e       pkt;
        logic [1:0] dst_y;
        logic [1:0] dst_x;
        logic [1:0] src_y;
        logic [1:0] src_x;
        logic [3:0] id;
        logic [1:0] resp;
        logic [3:0] strb;
    } head_t;

    function automatic logic is_head(input flit_type_e t);
        return t[0];
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return t[1];
    endfunction

    // dst is ADDR[31:28] = {dst_y, dst_x}
    function automatic logic dst_bad(input logic [3:0] dst, input int dim);
        return (int'({30'd0, dst[3:2]}) >= dim) ||
               (int'({30'd0, dst[1:0]}) >= dim);
    endfunction

endpackage

// File: rtl/noc_flit_pack.sv
// Combinational head-flit builder (TX) and flit decoder (RX).
// Non-head TX flits carry tx_payload verbatim.
module noc_flit_pack
    import noc_pkg::*;
(
    input  flit_type_e        tx_type,
    input  head_t             tx_head,
    input  logic [31:0]       tx_payload,
    output logic [FLIT_W-1:0] tx_flit,
    input  logic [FLIT_W-1:0] rx_flit,
    output flit_type_e        rx_type,
    output head_t             rx_head,
    output logic [31:0]       rx_payload
);

    logic [31:0] head_word;

    always_comb begin
        head_word = '0;
        head_word[HB_PKT+:2]  = tx_head.pkt;
        head_word[HB_DY+:2]   = tx_head.dst_y;
        head_word[HB_DX+:2]   = tx_head.dst_x;
        head_word[HB_SY+:2]   = tx_head.src_y;
        head_word[HB_SX+:2]   = tx_head.src_x;
        head_word[HB_ID+:4]   = tx_head.id;
        head_word[HB_RESP+:2] = tx_head.resp;
        head_word[HB_STRB+:4] = tx_head.strb;
    end

    assign tx_flit = {tx_type, is_head(tx_type) ? head_word : tx_payload};

    assign rx_type    = flit_type_e'(rx_flit[FLIT_W-1 -: 2]);
    assign rx_payload = rx_flit[31:0];

    always_comb begin
        rx_head.pkt   = pkt_e'(rx_flit[HB_PKT+:2]);
        rx_head.dst_y = rx_flit[HB_DY+:2];
        rx_head.dst_x = rx_flit[HB_DX+:2];
        rx_head.src_y = rx_flit[HB_SY+:2];
        rx_head.src_x = rx_flit[HB_SX+:2];
        rx_head.id    = rx_flit[HB_ID+:4];
        rx_head.resp  = rx_flit[HB_RESP+:2];
        rx_head.strb  = rx_flit[HB_STRB+:4];
    end

endmodule

// File: rtl/axi_noc_ni.sv
// AXI4 slave network interface: single-beat transactions to mesh packets,
// one outstanding transaction, bursts and bad destinations answered locally.
module axi_noc_ni #(
    parameter logic [1:0] SRC_X    = 2'd0,
    parameter logic [1:0] SRC_Y    = 2'd0,
    parameter int         MESH_DIM = 3,
    parameter int         FLIT_W   = 34
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [3:0]        AWID,
    input  logic [31:0]       AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [3:0]        BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [3:0]        ARID,
    input  logic [31:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [3:0]        RID,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_out_valid,
    input  logic              flit_out_ready,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_valid,
    output logic              flit_in_ready
);
    import noc_pkg::*;

    state_e      state_q, state_d;
    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        rd_q;
    logic [1:0]  resp_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        disc_q;
    logic        pref_rd_q;

    logic        wr_elig, rd_elig, in_idle;
    logic        gnt_wr, gnt_rd;
    logic        aw_bad, ar_bad;
    logic        rsp_hit;
    pkt_e        exp_pkt;

    flit_type_e  tx_type;
    logic [31:0] tx_payload;
    head_t       tx_head;
    flit_type_e  rx_type;
    head_t       rx_head;
    logic [31:0] rx_payload;
    logic        unused_ok;

    // Readies are gated by reset so nothing handshakes while held in reset.
    assign in_idle = ARESETn && (state_q == S_IDLE);
    assign wr_elig = AWVALID && WVALID;
    assign rd_elig = ARVALID;
    assign gnt_wr  = in_idle && wr_elig && (!rd_elig || !pref_rd_q);
    assign gnt_rd  = in_idle && rd_elig && (!wr_elig || pref_rd_q);

    assign aw_bad = dst_bad(AWADDR[31:28], MESH_DIM);
    assign ar_bad = dst_bad(ARADDR[31:28], MESH_DIM);

    assign exp_pkt = rd_q ? PKT_RRSP : PKT_WRSP;
    assign rsp_hit = (state_q == S_WAIT_RSP) && flit_in_valid && !disc_q &&
                     is_head(rx_type) && (rx_head.pkt == exp_pkt) &&
                     (rx_head.id == id_q);

    assign AWREADY = gnt_wr;
    assign WREADY  = gnt_wr || (state_q == S_W_DRAIN);
    assign ARREADY = gnt_rd;

    assign BVALID = (state_q == S_B_OUT);
    assign BID    = id_q;
    assign BRESP  = resp_q;
    assign RVALID = (state_q == S_R_OUT);
    assign RID    = id_q;
    assign RDATA  = rdata_q;
    assign RRESP  = resp_q;
    assign RLAST  = (state_q == S_R_OUT) && (cnt_q == 8'd0);

    assign flit_out_valid = (state_q == S_TX_HEAD) ||
                            (state_q == S_TX_ADDR) ||
                            (state_q == S_TX_DATA);
    assign flit_in_ready  = (state_q == S_WAIT_RSP) ||
                            (state_q == S_RX_DATA);

    always_comb begin
        tx_type    = FT_BODY;
        tx_payload = '0;
        case (state_q)
            S_TX_HEAD: tx_type = FT_HEAD;
            S_TX_ADDR: begin
                tx_type    = rd_q ? FT_TAIL : FT_BODY;
                tx_payload = addr_q;
            end
            S_TX_DATA: begin
                tx_type    = FT_TAIL;
                tx_payload = data_q;
            end
            default: ;
        endcase
    end

    assign tx_head = '{
        pkt:   rd_q ? PKT_RREQ : PKT_WREQ,
        dst_y: addr_q[31:30],
        dst_x: addr_q[29:28],
        src_y: SRC_Y,
        src_x: SRC_X,
        id:    id_q,
        resp:  RESP_OKAY,
        strb:  strb_q
    };

    noc_flit_pack u_pack (
        .tx_type    (tx_type),
        .tx_head    (tx_head),
        .tx_payload (tx_payload),
        .tx_flit    (flit_out),
        .rx_flit    (flit_in),
        .rx_type    (rx_type),
        .rx_head    (rx_head),
        .rx_payload (rx_payload)
    );

    assign unused_ok = ^{rx_head.dst_y, rx_head.dst_x, rx_head.src_y,
                         rx_head.src_x, rx_head.strb};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_wr) begin
                    if (AWLEN != 8'd0)
                        state_d = WLAST ? S_B_OUT : S_W_DRAIN;
                    else if (aw_bad)
                        state_d = S_B_OUT;
                    else
                        state_d = S_TX_HEAD;
                end else if (gnt_rd) begin
                    if ((ARLEN != 8'd0) || ar_bad)
                        state_d = S_R_OUT;
                    else
                        state_d = S_TX_HEAD;
                end
            end
            S_TX_HEAD:
                if (flit_out_ready) state_d = S_TX_ADDR;
            S_TX_ADDR:
                if (flit_out_ready) state_d = rd_q ? S_WAIT_RSP : S_TX_DATA;
            S_TX_DATA:
                if (flit_out_ready) state_d = S_WAIT_RSP;
            S_WAIT_RSP:
                if (rsp_hit) state_d = rd_q ? S_RX_DATA : S_B_OUT;
            S_RX_DATA:
                if (flit_in_valid && is_tail(rx_type)) state_d = S_R_OUT;
            S_B_OUT:
                if (BREADY) state_d = S_IDLE;
            S_R_OUT:
                if (RREADY && (cnt_q == 8'd0)) state_d = S_IDLE;
            S_W_DRAIN:
                if (WVALID && WLAST) state_d = S_B_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            rd_q      <= 1'b0;
            resp_q    <= RESP_OKAY;
            cnt_q     <= '0;
            rdata_q   <= '0;
            disc_q    <= 1'b0;
            pref_rd_q <= 1'b0;
        end else begin
            if (gnt_wr) begin
                id_q      <= AWID;
                addr_q    <= AWADDR;
                data_q    <= WDATA;
                strb_q    <= WSTRB;
                rd_q      <= 1'b0;
                cnt_q     <= '0;
                rdata_q   <= '0;
                pref_rd_q <= 1'b1;
                resp_q    <= (AWLEN != 8'd0) ? RESP_SLVERR :
                             aw_bad ? RESP_DECERR : RESP_OKAY;
            end else if (gnt_rd) begin
                id_q      <= ARID;
                addr_q    <= ARADDR;
                data_q    <= '0;
                strb_q    <= '0;
                rd_q      <= 1'b1;
                cnt_q     <= ARLEN;
                rdata_q   <= '0;
                pref_rd_q <= 1'b0;
                resp_q    <= (ARLEN != 8'd0) ? RESP_SLVERR :
                             ar_bad ? RESP_DECERR : RESP_OKAY;
            end
            if (rsp_hit)
                resp_q <= rx_head.resp;
            // Foreign multi-flit packets are swallowed up to their tail.
            if ((state_q == S_WAIT_RSP) && flit_in_valid) begin
                if (disc_q)
                    disc_q <= !is_tail(rx_type);
                else if (is_head(rx_type) && !is_tail(rx_type) && !rsp_hit)
                    disc_q <= 1'b1;
            end
            if ((state_q == S_RX_DATA) && flit_in_valid && is_tail(rx_type))
                rdata_q <= rx_payload;
            if ((state_q == S_R_OUT) && RREADY && (cnt_q != 8'd0))
                cnt_q <= cnt_q - 8'd1;
        end
    end

endmodule
